// File: rtl/aes_pkg.sv
// Shared AES datapath types and widths.
package aes_pkg;
   localparam int unsigned BLOCK_W         = 128;
   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned BYTES_PER_BLOCK = 16;
   localparam int unsigned BCNT_W          = $clog2(BYTES_PER_BLOCK);

   typedef logic [BLOCK_W-1:0] block_t;
   typedef logic [BYTE_W-1:0]  byte_t;
endpackage

// File: rtl/rx_buffer_if.sv
// Receiver-to-AES bus: byte input side, block FIFO read side and status flags.
interface rx_buffer_if;
   import aes_pkg::*;

   byte_t  din;
   logic   ready;
   logic   re;
   block_t dout;
   logic   empty;
   logic   of;

   modport master (output din, ready, re, input dout, empty, of);
   modport slave  (input din, ready, re, output dout, empty, of);
endinterface

// File: rtl/block_fifo.sv
// First-word-fall-through FIFO of 128-bit blocks; head is visible combinationally.
module block_fifo
   import aes_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   wr_en_i,
   input  block_t wr_data_i,
   input  logic   rd_en_i,
   output block_t head_c,
   output logic   full_c,
   output logic   empty_c
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   block_t           mem_q [DEPTH];
   logic             wr_fire_c;
   logic             rd_fire_c;

   assign full_c    = (count_q == CNT_W'(DEPTH));
   assign empty_c   = (count_q == '0);
   assign head_c    = mem_q[rd_ptr_q];
   assign rd_fire_c = rd_en_i & ~empty_c;
   // A pop in the same cycle frees the slot, so a write while full still lands.
   assign wr_fire_c = wr_en_i & (~full_c | rd_fire_c);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_fire_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_fire_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_fire_c, rd_fire_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (wr_fire_c) mem_q[wr_ptr_q] <= wr_data_i;
      end
   end
endmodule

// File: rtl/rx_buffer.sv
// Assembles received bytes into 128-bit blocks and queues them for the AES core.
module rx_buffer
   import aes_pkg::*;
#(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned BYTES_PER_BLOCK = 16
) (
   input  logic        clk,
   input  logic        reset,
   rx_buffer_if.slave  bus
);
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_BLOCK - 1);

   logic              ready_q, ready_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   block_t            asm_q, asm_d;
   logic              of_q, of_d;
   logic              capture_c;
   logic              commit_c;
   logic              pop_c;
   logic              full_c;
   logic              empty_c;
   block_t            head_c;

   // Byte assembly: first byte lands in the MSB byte lane.
   always_comb begin
      ready_d   = bus.ready;
      asm_d     = asm_q;
      bcnt_d    = bcnt_q;
      commit_c  = 1'b0;
      capture_c = bus.ready & ~ready_q;
      if (capture_c) begin
         for (int unsigned k = 0; k < BYTES_PER_BLOCK; k++) begin
            if (bcnt_q == BCNT_W'(k)) asm_d[BLOCK_W-1-BYTE_W*k -: BYTE_W] = bus.din;
         end
         if (bcnt_q == LAST_BYTE) begin
            commit_c = 1'b1;
            bcnt_d   = '0;
         end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
         end
      end
   end

   assign pop_c = bus.re & ~empty_c;
   assign of_d  = of_q | (commit_c & full_c & ~pop_c);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q <= 1'b0;
         bcnt_q  <= '0;
         asm_q   <= '0;
         of_q    <= 1'b0;
      end else begin
         ready_q <= ready_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         of_q    <= of_d;
      end
   end

   block_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .wr_en_i   (commit_c),
      .wr_data_i (asm_d),
      .rd_en_i   (bus.re),
      .head_c    (head_c),
      .full_c    (full_c),
      .empty_c   (empty_c)
   );

   assign bus.dout  = head_c;
   assign bus.empty = empty_c;
   assign bus.of    = of_q;
endmodule

// File: tb/tb_rx_buffer.sv
// Directed bench for rx_buffer: byte assembly, FWFT reads, overflow and reset corners.
module tb_rx_buffer;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   rx_buffer_if bus_if ();

   rx_buffer #(.DEPTH(4), .BYTES_PER_BLOCK(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] make_block(input logic [7:0] base);
      logic [127:0] blk;
      blk = '0;
      for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = base + 8'(k);
      return blk;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
      bus_if.din   = b;
      bus_if.ready = 1'b1;
      repeat (hi) @(negedge clk);
      bus_if.ready = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic send_bytes(input logic [127:0] blk, input int first, input int last,
                             input int hi, input int lo);
      for (int k = first; k <= last; k++) send_byte(blk[127-8*k -: 8], hi, lo);
   endtask

   task automatic pop();
      bus_if.re = 1'b1;
      @(negedge clk);
      bus_if.re = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", bus_if.empty); end
      tests++; if (bus_if.of !== 1'b0) begin fails++; $display("FAIL reset_of got=%b exp=0", bus_if.of); end
      tests++; if (bus_if.dout !== 128'h0) begin fails++; $display("FAIL reset_dout got=%h exp=0", bus_if.dout); end
      reset = 1'b1;
      repeat (4) @(negedge clk);
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL idle_empty got=%b exp=1", bus_if.empty); end
      tests++; if (bus_if.of !== 1'b0) begin fails++; $display("FAIL idle_of got=%b exp=0", bus_if.of); end
      tests++; if (bus_if.dout !== 128'h0) begin fails++; $display("FAIL idle_dout got=%h exp=0", bus_if.dout); end
   endtask

   task automatic test_block1();
      logic [127:0] exp;
      exp = 128'h55AA55AA55AA55AA55AA55AA55AA55AA;
      send_bytes(exp, 0, 14, 2, 7);
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL b1_empty_after15 got=%b exp=1", bus_if.empty); end
      send_bytes(exp, 15, 15, 2, 7);
      tests++; if (bus_if.empty !== 1'b0) begin fails++; $display("FAIL b1_empty_after16 got=%b exp=0", bus_if.empty); end
      tests++; if (bus_if.dout !== exp) begin fails++; $display("FAIL b1_dout got=%h exp=%h", bus_if.dout, exp); end
      pop();
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL b1_empty_after_pop got=%b exp=1", bus_if.empty); end
   endtask

   task automatic test_two_blocks();
      logic [127:0] b1;
      logic [127:0] b2;
      b1 = 128'h55AA55AA55AA55AA55AA55AA55AA55AA;
      b2 = {16{8'hF1}};
      send_bytes(b1, 0, 15, 2, 2);
      send_bytes(b2, 0, 15, 2, 2);
      tests++; if (bus_if.dout !== b1) begin fails++; $display("FAIL two_head1 got=%h exp=%h", bus_if.dout, b1); end
      pop();
      tests++; if (bus_if.dout !== b2) begin fails++; $display("FAIL two_head2 got=%h exp=%h", bus_if.dout, b2); end
      tests++; if (bus_if.empty !== 1'b0) begin fails++; $display("FAIL two_empty1 got=%b exp=0", bus_if.empty); end
      pop();
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL two_empty2 got=%b exp=1", bus_if.empty); end
   endtask

   task automatic test_overflow();
      logic [127:0] exp;
      for (int i = 0; i < 4; i++) send_bytes(make_block(8'h10 * 8'(i + 1)), 0, 15, 2, 2);
      tests++; if (bus_if.of !== 1'b0) begin fails++; $display("FAIL ovf_of_full got=%b exp=0", bus_if.of); end
      send_bytes(make_block(8'hA0), 0, 14, 2, 2);
      tests++; if (bus_if.of !== 1'b0) begin fails++; $display("FAIL ovf_of_15 got=%b exp=0", bus_if.of); end
      send_bytes(make_block(8'hA0), 15, 15, 2, 2);
      tests++; if (bus_if.of !== 1'b1) begin fails++; $display("FAIL ovf_of_16 got=%b exp=1", bus_if.of); end
      for (int i = 0; i < 4; i++) begin
         exp = make_block(8'h10 * 8'(i + 1));
         tests++; if (bus_if.dout !== exp) begin fails++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, bus_if.dout, exp); end
         pop();
      end
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL ovf_empty got=%b exp=1", bus_if.empty); end
      tests++; if (bus_if.of !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", bus_if.of); end
   endtask

   task automatic test_re_empty();
      logic [127:0] exp;
      apply_reset();
      pop();
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL reempty_empty got=%b exp=1", bus_if.empty); end
      tests++; if (bus_if.dout !== 128'h0) begin fails++; $display("FAIL reempty_dout got=%h exp=0", bus_if.dout); end
      tests++; if (bus_if.of !== 1'b0) begin fails++; $display("FAIL reempty_of got=%b exp=0", bus_if.of); end
      exp = make_block(8'h21);
      send_bytes(exp, 0, 15, 2, 2);
      tests++; if (bus_if.dout !== exp) begin fails++; $display("FAIL reempty_next got=%h exp=%h", bus_if.dout, exp); end
      pop();
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL reempty_drain got=%b exp=1", bus_if.empty); end
   endtask

   task automatic test_full_pop();
      logic [127:0] last;
      logic [127:0] exp;
      for (int i = 0; i < 4; i++) send_bytes(make_block(8'h30 + 8'h10 * 8'(i)), 0, 15, 2, 2);
      last = make_block(8'h70);
      send_bytes(last, 0, 14, 2, 2);
      // 16th byte captured on the same edge that samples re high.
      bus_if.din   = last[7:0];
      bus_if.ready = 1'b1;
      bus_if.re    = 1'b1;
      @(negedge clk);
      bus_if.re    = 1'b0;
      @(negedge clk);
      bus_if.ready = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (bus_if.of !== 1'b0) begin fails++; $display("FAIL fullpop_of got=%b exp=0", bus_if.of); end
      for (int i = 0; i < 4; i++) begin
         exp = make_block(8'h40 + 8'h10 * 8'(i));
         tests++; if (bus_if.empty !== 1'b0) begin fails++; $display("FAIL fullpop_empty%0d got=%b exp=0", i, bus_if.empty); end
         tests++; if (bus_if.dout !== exp) begin fails++; $display("FAIL fullpop_head%0d got=%h exp=%h", i, bus_if.dout, exp); end
         pop();
      end
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL fullpop_drained got=%b exp=1", bus_if.empty); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] exp;
      apply_reset();
      send_bytes(make_block(8'h80), 0, 6, 2, 2);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL midrst_empty got=%b exp=1", bus_if.empty); end
      exp = make_block(8'hC0);
      send_bytes(exp, 0, 14, 2, 2);
      tests++; if (bus_if.empty !== 1'b1) begin fails++; $display("FAIL midrst_early got=%b exp=1", bus_if.empty); end
      send_bytes(exp, 15, 15, 2, 2);
      tests++; if (bus_if.empty !== 1'b0) begin fails++; $display("FAIL midrst_commit got=%b exp=0", bus_if.empty); end
      tests++; if (bus_if.dout !== exp) begin fails++; $display("FAIL midrst_dout got=%h exp=%h", bus_if.dout, exp); end
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      reset        = 1'b0;
      bus_if.din   = 8'h00;
      bus_if.ready = 1'b0;
      bus_if.re    = 1'b0;
      test_reset();
      test_block1();
      test_two_blocks();
      test_overflow();
      test_re_empty();
      test_full_pop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
